// File: rtl/accel_sample_filter.sv
// Accelerometer sample filter: syncs the I2C idle flag, captures each word,
// runs a signed moving average, and drives tilt and stale-data flags.
module accel_sample_filter #(
   parameter int unsigned       LOG2_DEPTH     = 3,
   parameter int unsigned       SETTLE_CYCLES  = 4,
   parameter int unsigned       TIMEOUT_CYCLES = 25000000,
   parameter logic signed [15:0] HI_THRESH     = 16'sd8192,
   parameter logic signed [15:0] LO_THRESH     = 16'sd4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] reading,
   input  logic        bus_idle,
   output logic [15:0] raw_sample,
   output logic        raw_valid,
   output logic [15:0] filtered,
   output logic        filtered_valid,
   output logic        sample_strobe,
   output logic        tilt,
   output logic        stale,
   output logic [15:0] sample_count
);

   localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
   localparam int unsigned SW    = 16 + LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FULL =
      (LOG2_DEPTH + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_WAIT,
      S_SETTLE,
      S_CAPTURE,
      S_UPDATE,
      S_OUTPUT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic s1;
   logic s2;
   logic s3;
   logic rise;

   logic [31:0] settle_cnt;
   logic        cnt_clr;
   logic        cnt_inc;
   logic        cap_en;
   logic        upd_en;
   logic        out_en;

   logic signed [15:0]   raw_q;
   logic signed [15:0]   win_buf [DEPTH];
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] new_ext;
   logic signed [SW-1:0] old_ext;
   logic signed [15:0]   avg;
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH:0]   fill;

   logic [31:0] wd_cnt;

   // Three-flop synchroniser for the asynchronous idle flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus_idle;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; rises outside WAIT are dropped
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_WAIT: begin
            if (rise) begin
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_cnt == SETTLE_CYCLES - 1) begin
               state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: state_nxt = S_UPDATE;
         S_UPDATE:  state_nxt = S_OUTPUT;
         S_OUTPUT:  state_nxt = S_WAIT;
         default:   state_nxt = S_WAIT;
      endcase
   end

   // FSM output decode into per-stage enables
   always_comb begin
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      cap_en  = 1'b0;
      upd_en  = 1'b0;
      out_en  = 1'b0;
      unique case (state)
         S_WAIT:    cnt_clr = 1'b1;
         S_SETTLE:  cnt_inc = 1'b1;
         S_CAPTURE: cap_en  = 1'b1;
         S_UPDATE:  upd_en  = 1'b1;
         S_OUTPUT:  out_en  = 1'b1;
         default:   cnt_clr = 1'b1;
      endcase
   end

   // Settle delay counter, restarted every time the FSM sits in WAIT
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_cnt <= '0;
      end else if (cnt_clr) begin
         settle_cnt <= '0;
      end else if (cnt_inc) begin
         settle_cnt <= settle_cnt + 32'd1;
      end
   end

   // Capture stage: latch the word and count captures
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         raw_q        <= '0;
         raw_valid    <= 1'b0;
         sample_count <= '0;
      end else if (cap_en) begin
         raw_q        <= reading;
         raw_valid    <= 1'b1;
         sample_count <= sample_count + 16'd1;
      end
   end

   assign raw_sample = raw_q;

   assign new_ext = SW'(raw_q);
   assign old_ext = SW'(win_buf[wr_ptr]);

   // Window update: running sum swaps the oldest entry for the newest
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            win_buf[i] <= '0;
         end
         sum    <= '0;
         wr_ptr <= '0;
         fill   <= '0;
      end else if (upd_en) begin
         sum             <= sum + new_ext - old_ext;
         win_buf[wr_ptr] <= raw_q;
         wr_ptr          <= wr_ptr + 1'b1;
         if (fill != FULL) begin
            fill <= fill + 1'b1;
         end
      end
   end

   assign avg = 16'(sum >>> LOG2_DEPTH);

   // Output stage: publish the average, strobe, and hysteretic tilt
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         filtered       <= '0;
         filtered_valid <= 1'b0;
         sample_strobe  <= 1'b0;
         tilt           <= 1'b0;
      end else begin
         sample_strobe <= out_en;
         if (out_en) begin
            filtered       <= avg;
            filtered_valid <= (fill == FULL);
            if (fill == FULL) begin
               if (avg > HI_THRESH) begin
                  tilt <= 1'b1;
               end else if (avg < LO_THRESH) begin
                  tilt <= 1'b0;
               end
            end
         end
      end
   end

   // Stale watchdog: saturating count of clocks since the last capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
         stale  <= 1'b0;
      end else if (cap_en) begin
         wd_cnt <= '0;
         stale  <= 1'b0;
      end else if (wd_cnt != TIMEOUT_CYCLES) begin
         wd_cnt <= wd_cnt + 32'd1;
         if (wd_cnt == TIMEOUT_CYCLES - 1) begin
            stale <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_accel_sample_filter.sv
// Directed bench for accel_sample_filter: vector table for the averaging
// path plus hand-written sequences for reset, watchdog and glitch cases.
module tb_accel_sample_filter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        bus_idle = 1'b0;
   logic [15:0] reading = '0;
   logic [15:0] raw_sample;
   logic        raw_valid;
   logic [15:0] filtered;
   logic        filtered_valid;
   logic        sample_strobe;
   logic        tilt;
   logic        stale;
   logic [15:0] sample_count;

   int errors = 0;
   int checks = 0;

   accel_sample_filter #(
      .LOG2_DEPTH     (3),
      .SETTLE_CYCLES  (4),
      .TIMEOUT_CYCLES (100),
      .HI_THRESH      (16'sd8192),
      .LO_THRESH      (16'sd4096)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .reading        (reading),
      .bus_idle       (bus_idle),
      .raw_sample     (raw_sample),
      .raw_valid      (raw_valid),
      .filtered       (filtered),
      .filtered_valid (filtered_valid),
      .sample_strobe  (sample_strobe),
      .tilt           (tilt),
      .stale          (stale),
      .sample_count   (sample_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] rd;
      logic [15:0] filt;
      logic        chk_filt;
      logic        fvalid;
      logic [15:0] cnt;
      logic        tilt;
   } vec_t;

   vec_t vecs[48];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drop idle, load a word, raise idle; lat = clocks from s1 edge to strobe
   task automatic pulse(input logic [15:0] v, output int lat);
      @(negedge clock);
      bus_idle = 1'b0;
      reading  = v;
      repeat (3) @(posedge clock);
      @(negedge clock);
      bus_idle = 1'b1;
      @(posedge clock);
      lat = 0;
      do begin
         @(posedge clock);
         #1;
         lat++;
      end while (!sample_strobe && lat < 40);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int lat;
      int nstb;

      k = 0;
      for (int i = 1; i <= 8; i++) begin
         vecs[k] = '{16'h0100, 16'(32 * i), 1'b1, (i == 8),
                     16'(i), 1'b0};
         k++;
      end
      for (int i = 1; i <= 4; i++) begin
         vecs[k] = '{16'hFF00, 16'(256 - 64 * i), 1'b1, 1'b1,
                     16'(8 + i), 1'b0};
         k++;
      end
      for (int i = 1; i <= 4; i++) begin
         vecs[k] = '{16'hFF00, 16'(-64 * i), 1'b1, 1'b1,
                     16'(12 + i), 1'b0};
         k++;
      end
      for (int i = 1; i <= 8; i++) begin
         vecs[k] = '{16'd9000, 16'd9000, (i == 8), 1'b1,
                     16'(16 + i), (i == 8)};
         k++;
      end
      for (int i = 1; i <= 8; i++) begin
         vecs[k] = '{16'd6000, 16'd6000, (i == 8), 1'b1,
                     16'(24 + i), 1'b1};
         k++;
      end
      for (int i = 1; i <= 8; i++) begin
         vecs[k] = '{16'd4000, (i == 7) ? 16'd4250 : 16'd4000,
                     (i >= 7), 1'b1, 16'(32 + i), (i < 8)};
         k++;
      end
      for (int i = 1; i <= 8; i++) begin
         vecs[k] = '{16'd6000, 16'd6000, (i == 8), 1'b1,
                     16'(40 + i), 1'b0};
         k++;
      end

      // Reset state
      #12;
      chk("rst raw_sample", raw_sample, 0);
      chk("rst raw_valid", raw_valid, 0);
      chk("rst filtered", filtered, 0);
      chk("rst fvalid", filtered_valid, 0);
      chk("rst strobe", sample_strobe, 0);
      chk("rst tilt", tilt, 0);
      chk("rst stale", stale, 0);
      chk("rst count", sample_count, 0);
      @(negedge clock);
      reset = 1'b1;

      // Table: fill, signed average, hysteresis
      for (int i = 0; i < 48; i++) begin
         pulse(vecs[i].rd, lat);
         chk($sformatf("v%0d latency", i), lat, 9);
         chk($sformatf("v%0d raw", i), raw_sample, vecs[i].rd);
         chk($sformatf("v%0d raw_valid", i), raw_valid, 1);
         if (vecs[i].chk_filt) begin
            chk($sformatf("v%0d filtered", i), filtered, vecs[i].filt);
         end
         chk($sformatf("v%0d fvalid", i), filtered_valid,
             vecs[i].fvalid);
         chk($sformatf("v%0d count", i), sample_count, vecs[i].cnt);
         chk($sformatf("v%0d tilt", i), tilt, vecs[i].tilt);
         @(posedge clock);
         #1;
         chk($sformatf("v%0d strobe_width", i), sample_strobe, 0);
      end

      // Idle glitch during SETTLE must not cause a second capture
      @(negedge clock);
      bus_idle = 1'b0;
      reading  = 16'h1234;
      repeat (3) @(posedge clock);
      @(negedge clock);
      bus_idle = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      bus_idle = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus_idle = 1'b1;
      nstb = 0;
      repeat (30) begin
         @(posedge clock);
         #1;
         if (sample_strobe) nstb++;
      end
      chk("glitch strobes", nstb, 1);
      chk("glitch count", sample_count, 49);
      chk("glitch raw", raw_sample, 16'h1234);

      // Watchdog: stale after 100 clocks without capture
      pulse(16'h0010, lat);
      chk("wd pre latency", lat, 9);
      repeat (97) @(posedge clock);
      #1;
      chk("wd stale@99", stale, 0);
      @(posedge clock);
      #1;
      chk("wd stale@100", stale, 1);
      repeat (20) @(posedge clock);
      #1;
      chk("wd stale hold", stale, 1);
      pulse(16'h0020, lat);
      chk("wd post latency", lat, 9);
      chk("wd stale cleared", stale, 0);

      // Asynchronous reset in the middle of a pending capture
      @(negedge clock);
      bus_idle = 1'b0;
      reading  = 16'h7FFF;
      repeat (3) @(posedge clock);
      @(negedge clock);
      bus_idle = 1'b1;
      repeat (5) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("mid raw_sample", raw_sample, 0);
      chk("mid raw_valid", raw_valid, 0);
      chk("mid filtered", filtered, 0);
      chk("mid fvalid", filtered_valid, 0);
      chk("mid strobe", sample_strobe, 0);
      chk("mid tilt", tilt, 0);
      chk("mid stale", stale, 0);
      chk("mid count", sample_count, 0);
      @(negedge clock);
      bus_idle = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Empty window: single -1 floors to -1, then partial fill
      pulse(16'hFFFF, lat);
      chk("neg latency", lat, 9);
      chk("neg filtered", filtered, 16'hFFFF);
      chk("neg fvalid", filtered_valid, 0);
      chk("neg count", sample_count, 1);
      for (int i = 2; i <= 8; i++) begin
         pulse(16'h0000, lat);
         chk($sformatf("post%0d filtered", i), filtered, 16'hFFFF);
         chk($sformatf("post%0d fvalid", i), filtered_valid, (i == 8));
         chk($sformatf("post%0d count", i), sample_count, i);
      end
      chk("post tilt", tilt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
